// File: rtl/scan_dec_pkg.sv
// scan_dec_pkg: FSM state encoding and output polarity constants shared by the scan decoder.
package scan_dec_pkg;
   typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
   localparam logic POL_HIGH = 1'b1;
   localparam logic POL_LOW  = 1'b0;
endpackage

// File: rtl/dec_onehot.sv
// dec_onehot: combinational index to one-hot (ACT_HIGH=1) or one-cold (ACT_HIGH=0) decoder.
module dec_onehot
   import scan_dec_pkg::*;
#(
   parameter int SEL_W    = 2,
   parameter bit ACT_HIGH = POL_HIGH
) (
   input  logic [SEL_W-1:0]      i_idx,
   output logic [2**SEL_W-1:0]   o_dout
);
   localparam int NOUT = 2**SEL_W;
   logic [NOUT-1:0] w_hot;
   assign w_hot  = NOUT'(1) << i_idx;
   assign o_dout = (ACT_HIGH == POL_HIGH) ? w_hot : ~w_hot;
endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered direct-select / auto-scan output decoder with enable freeze.
// Optional sticky err output (sel_valid seen while scanning) under SCAN_DECODER_ERR_EN.
module scan_decoder
   import scan_dec_pkg::*;
#(
   parameter int SEL_W    = 2,
   parameter bit ACT_HIGH = POL_HIGH,
   parameter int DWELL_W  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 mode,
   input  logic                 sel_valid,
   input  logic [SEL_W-1:0]     sel,
   output logic                 sel_ready,
   input  logic [DWELL_W-1:0]   dwell,
   output logic [2**SEL_W-1:0]  dout,
   output logic [SEL_W-1:0]     cur_idx,
   output logic                 wrap
`ifdef SCAN_DECODER_ERR_EN
   ,
   output logic                 err
`endif
);
   localparam int NOUT = 2**SEL_W;
   localparam logic [NOUT-1:0] INACT = (ACT_HIGH == POL_HIGH) ? '0 : '1;

   state_t               r_state;
   logic [SEL_W-1:0]     r_idx;
   logic [DWELL_W-1:0]   r_cnt;
   logic [DWELL_W-1:0]   r_dwell;
   logic [NOUT-1:0]      r_dout;
   logic                 r_on;
   logic                 r_wrap;
   logic                 w_xfer;
   logic                 w_take;
   logic                 w_entry;
   logic                 w_adv;
   logic [SEL_W-1:0]     w_nidx;
   logic [NOUT-1:0]      w_dec;

   assign sel_ready = rst_n & en & (r_state != SCAN);
   assign w_xfer    = sel_valid & sel_ready;
   // scan entry wins over a transfer offered on the same edge
   assign w_take    = w_xfer & ~mode;
   assign w_entry   = en & mode & (r_state != SCAN);
   assign w_adv     = en & mode & (r_state == SCAN) & (r_cnt == r_dwell);
   assign w_nidx    = w_entry ? '0 : w_adv ? r_idx + 1'b1 : w_take ? sel : r_idx;

   dec_onehot #(.SEL_W(SEL_W), .ACT_HIGH(ACT_HIGH)) u_dec (
      .i_idx  (w_nidx),
      .o_dout (w_dec)
   );

   // r_dout keeps the logical selection across an en=0 pause; r_on blanks it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_dwell <= '0;
         r_dout  <= INACT;
         r_on    <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_on   <= en;
         r_wrap <= w_adv & (&r_idx);
         if (en) begin
            r_state <= mode ? SCAN : DIRECT;
            r_idx   <= w_nidx;
            if (w_entry | w_adv) begin
               r_cnt   <= '0;
               r_dwell <= dwell;
            end else if (mode) begin
               r_cnt <= r_cnt + 1'b1;
            end
            if (w_entry | w_adv | w_take) r_dout <= w_dec;
         end
      end
   end

   assign dout    = r_on ? r_dout : INACT;
   assign cur_idx = r_idx;
   assign wrap    = r_wrap & en;

`ifdef SCAN_DECODER_ERR_EN
   logic r_err;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_err <= 1'b0;
      else if (en & sel_valid & (r_state == SCAN)) r_err <= 1'b1;
   end
   assign err = r_err;
`endif
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed checks of an active-high and an active-low scan_decoder sharing stimulus.
module tb_scan_decoder;
   logic       clk = 1'b0;
   logic       rst_n, en, mode, sel_valid;
   logic [1:0] sel;
   logic [3:0] dwell;
   logic [3:0] dout_hi, dout_lo;
   logic [1:0] idx_hi, idx_lo;
   logic       rdy_hi, rdy_lo, wrap_hi, wrap_lo;
`ifdef SCAN_DECODER_ERR_EN
   logic       err_hi, err_lo;
`endif
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   scan_decoder #(.SEL_W(2), .ACT_HIGH(1'b1), .DWELL_W(4)) u_hi (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid), .sel(sel),
      .sel_ready(rdy_hi), .dwell(dwell), .dout(dout_hi), .cur_idx(idx_hi), .wrap(wrap_hi)
`ifdef SCAN_DECODER_ERR_EN
      , .err(err_hi)
`endif
   );

   scan_decoder #(.SEL_W(2), .ACT_HIGH(1'b0), .DWELL_W(4)) u_lo (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid), .sel(sel),
      .sel_ready(rdy_lo), .dwell(dwell), .dout(dout_lo), .cur_idx(idx_lo), .wrap(wrap_lo)
`ifdef SCAN_DECODER_ERR_EN
      , .err(err_lo)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = 2'd0; dwell = 4'd0;
      tick();
      n_checks++; if (dout_hi !== 4'b0000) begin n_fail++; $display("FAIL reset_dout_hi got %b want 0000", dout_hi); end
      n_checks++; if (dout_lo !== 4'b1111) begin n_fail++; $display("FAIL reset_dout_lo got %b want 1111", dout_lo); end
      n_checks++; if (idx_hi !== 2'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", idx_hi); end
      n_checks++; if (rdy_hi !== 1'b0 || wrap_hi !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_wrap got %b%b want 00", rdy_hi, wrap_hi); end
      rst_n = 1'b1; en = 1'b1;
      #1;
      n_checks++; if (rdy_hi !== 1'b1) begin n_fail++; $display("FAIL idle_ready got %b want 1", rdy_hi); end
      tick();
      n_checks++; if (dout_hi !== 4'b0000) begin n_fail++; $display("FAIL direct_no_xfer got %b want 0000", dout_hi); end
   endtask

   task automatic test_direct();
      logic [3:0] exp, prev;
      prev = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         sel = 2'(i); sel_valid = 1'b1;
         #1;
         n_checks++; if (dout_hi !== prev) begin n_fail++; $display("FAIL direct_latency%0d got %b want %b", i, dout_hi, prev); end
         tick();
         exp = 4'b0001 << i;
         n_checks++; if (dout_hi !== exp) begin n_fail++; $display("FAIL direct_dout%0d got %b want %b", i, dout_hi, exp); end
         n_checks++; if (idx_hi !== 2'(i)) begin n_fail++; $display("FAIL direct_idx%0d got %0d want %0d", i, idx_hi, i); end
         prev = exp;
      end
      sel_valid = 1'b0; sel = 2'd1;
      tick(); tick();
      n_checks++; if (dout_hi !== 4'b1000) begin n_fail++; $display("FAIL direct_hold got %b want 1000", dout_hi); end
   endtask

   task automatic test_polarity();
      sel = 2'd2; sel_valid = 1'b1;
      tick();
      sel_valid = 1'b0;
      n_checks++; if (dout_lo !== 4'b1011) begin n_fail++; $display("FAIL pol_lo_sel2 got %b want 1011", dout_lo); end
      n_checks++; if (dout_hi !== 4'b0100) begin n_fail++; $display("FAIL pol_hi_sel2 got %b want 0100", dout_hi); end
      en = 1'b0;
      #1;
      n_checks++; if (rdy_hi !== 1'b0) begin n_fail++; $display("FAIL en0_ready got %b want 0", rdy_hi); end
      tick();
      n_checks++; if (dout_lo !== 4'b1111) begin n_fail++; $display("FAIL en0_dout_lo got %b want 1111", dout_lo); end
      n_checks++; if (dout_hi !== 4'b0000) begin n_fail++; $display("FAIL en0_dout_hi got %b want 0000", dout_hi); end
      en = 1'b1;
      tick();
      n_checks++; if (dout_lo !== 4'b1011) begin n_fail++; $display("FAIL en1_resume_lo got %b want 1011", dout_lo); end
   endtask

   task automatic test_scan_dwell();
      logic [1:0] ei;
      logic [3:0] ed;
      int wraps;
      wraps = 0;
      dwell = 4'd2; mode = 1'b1;
      tick();
      n_checks++; if (rdy_hi !== 1'b0) begin n_fail++; $display("FAIL scan_ready got %b want 0", rdy_hi); end
      for (int n = 0; n <= 12; n++) begin
         if (n > 0) tick();
         ei = 2'((n / 3) % 4);
         ed = 4'b0001 << ei;
         if (wrap_hi) wraps++;
         n_checks++; if (idx_hi !== ei || dout_hi !== ed) begin n_fail++; $display("FAIL scan_d2_n%0d got idx %0d dout %b want idx %0d dout %b", n, idx_hi, dout_hi, ei, ed); end
         n_checks++; if (wrap_hi !== (n == 12)) begin n_fail++; $display("FAIL scan_d2_wrap_n%0d got %b want %b", n, wrap_hi, n == 12); end
      end
      n_checks++; if (wraps != 1) begin n_fail++; $display("FAIL scan_wrap_count got %0d want 1", wraps); end
      mode = 1'b0;
      tick();
      n_checks++; if (dout_hi !== 4'b0001 || rdy_hi !== 1'b1) begin n_fail++; $display("FAIL scan_exit got dout %b rdy %b want 0001 1", dout_hi, rdy_hi); end
   endtask

   task automatic test_pause();
      dwell = 4'd0; mode = 1'b1;
      tick(); tick(); tick();
      n_checks++; if (idx_hi !== 2'd2 || dout_hi !== 4'b0100) begin n_fail++; $display("FAIL pause_pre got idx %0d dout %b want 2 0100", idx_hi, dout_hi); end
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_checks++; if (dout_hi !== 4'b0000 || idx_hi !== 2'd2 || wrap_hi !== 1'b0) begin n_fail++; $display("FAIL pause_c%0d got dout %b idx %0d wrap %b want 0000 2 0", k, dout_hi, idx_hi, wrap_hi); end
      end
      en = 1'b1;
      tick();
      n_checks++; if (idx_hi !== 2'd3 || dout_hi !== 4'b1000 || wrap_hi !== 1'b0) begin n_fail++; $display("FAIL resume_3 got idx %0d dout %b wrap %b want 3 1000 0", idx_hi, dout_hi, wrap_hi); end
      tick();
      n_checks++; if (idx_hi !== 2'd0 || dout_hi !== 4'b0001 || wrap_hi !== 1'b1) begin n_fail++; $display("FAIL resume_0 got idx %0d dout %b wrap %b want 0 0001 1", idx_hi, dout_hi, wrap_hi); end
      tick();
      n_checks++; if (idx_hi !== 2'd1 || wrap_hi !== 1'b0) begin n_fail++; $display("FAIL resume_1 got idx %0d wrap %b want 1 0", idx_hi, wrap_hi); end
   endtask

   task automatic test_reset_mid();
      tick(); tick();
      n_checks++; if (idx_hi !== 2'd3) begin n_fail++; $display("FAIL premid_idx got %0d want 3", idx_hi); end
      #3 rst_n = 1'b0;
      #1;
      n_checks++; if (dout_hi !== 4'b0000 || dout_lo !== 4'b1111) begin n_fail++; $display("FAIL midrst_dout got %b %b want 0000 1111", dout_hi, dout_lo); end
      n_checks++; if (idx_hi !== 2'd0 || rdy_hi !== 1'b0 || wrap_hi !== 1'b0) begin n_fail++; $display("FAIL midrst_state got idx %0d rdy %b wrap %b want 0 0 0", idx_hi, rdy_hi, wrap_hi); end
      #2 rst_n = 1'b1;
      #1;
      n_checks++; if (rdy_hi !== 1'b1) begin n_fail++; $display("FAIL post_rst_idle got rdy %b want 1", rdy_hi); end
      tick();
      n_checks++; if (idx_hi !== 2'd0 || dout_hi !== 4'b0001 || rdy_hi !== 1'b0) begin n_fail++; $display("FAIL post_rst_scan got idx %0d dout %b rdy %b want 0 0001 0", idx_hi, dout_hi, rdy_hi); end
   endtask

`ifdef SCAN_DECODER_ERR_EN
   task automatic test_err();
      n_checks++; if (err_hi !== 1'b0) begin n_fail++; $display("FAIL err_init got %b want 0", err_hi); end
      sel_valid = 1'b1;
      tick();
      sel_valid = 1'b0;
      n_checks++; if (err_hi !== 1'b1 || err_lo !== 1'b1) begin n_fail++; $display("FAIL err_set got %b %b want 1 1", err_hi, err_lo); end
      mode = 1'b0;
      tick(); tick();
      n_checks++; if (err_hi !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", err_hi); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (err_hi !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b want 0", err_hi); end
      rst_n = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_direct();
      test_polarity();
      test_scan_dwell();
      test_pause();
      test_reset_mid();
`ifdef SCAN_DECODER_ERR_EN
      test_err();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 The block SHALL have parameter SEL_W, default 2, meaning select width; output count NOUT = 2**SEL_W, legal range 1..6.
REQ-002 The block SHALL have parameter ACT_HIGH, default 1, meaning output polarity: 1 gives an active-high one-hot output, 0 gives an active-low one-cold output.
REQ-003 The block SHALL have parameter DWELL_W, default 4, meaning the width of the scan dwell count.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: global enable; when low, all outputs are inactive and all state is held.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 selects direct decode, 1 selects auto-scan.
REQ-008 The block SHALL have port sel_valid, input, 1 bit: a direct-mode select request.
REQ-009 The block SHALL have port sel, input, SEL_W bits: the requested output index.
REQ-010 The block SHALL have port sel_ready, output, 1 bit: the block accepts sel on this cycle.
REQ-011 The block SHALL have port dwell, input, DWELL_W bits: the number of extra cycles each scan index is held.
REQ-012 The block SHALL have port dout, output, NOUT bits: the registered decoded output.
REQ-013 The block SHALL have port cur_idx, output, SEL_W bits: the index currently driven on dout.
REQ-014 The block SHALL have port wrap, output, 1 bit: a one-cycle pulse when the scan index wraps from NOUT-1 to 0.

Function
REQ-015 The block SHALL implement FSM states IDLE, DIRECT and SCAN.
REQ-016 IDLE SHALL move to DIRECT when en=1 and mode=0, and to SCAN when en=1 and mode=1.
REQ-017 When mode changes while en=1, the FSM SHALL switch state on the next edge.
REQ-018 While in DIRECT or IDLE, sel_ready SHALL be 1 when en=1; while in SCAN, sel_ready SHALL be 0.
REQ-019 A transfer (sel_valid & sel_ready) SHALL update cur_idx to sel and assert output bit sel on the next cycle, a latency of 1.
REQ-020 With no transfer in DIRECT, dout SHALL hold its last value.
REQ-021 In IDLE, dout SHALL be inactive.
REQ-022 On entry to SCAN, cur_idx SHALL be 0, the dwell counter SHALL be 0, and output 0 SHALL be active from the first SCAN cycle.
REQ-023 In SCAN, cur_idx SHALL advance by 1 after dwell+1 cycles at each index; dwell=0 gives an advance every cycle.
REQ-024 A dwell value changed mid-scan SHALL take effect from the next index.
REQ-025 When the scan advances from NOUT-1, cur_idx SHALL become 0 and wrap SHALL be 1 for exactly that cycle.
REQ-026 With SEL_W=1, the scan SHALL alternate between outputs 0 and 1.
REQ-027 "Inactive" SHALL mean all zeros when ACT_HIGH=1 and all ones when ACT_HIGH=0.
REQ-028 Active SHALL mean exactly one bit opposite to the inactive value.
REQ-029 When en=0, dout SHALL be inactive within 1 cycle, sel_ready and wrap SHALL be 0, and the FSM, cur_idx and dwell counter SHALL be frozen.
REQ-030 When en returns to 1, the block SHALL resume from the frozen state.
REQ-031 On an exit from SCAN to DIRECT, dout SHALL keep the last scan index until the next transfer.

Reset
REQ-032 Assertion of rst_n low SHALL immediately force the state to IDLE, cur_idx=0, dwell counter=0, dout inactive, sel_ready=0 and wrap=0, including in the middle of a scan.
REQ-033 The first transfer after reset release SHALL be accepted no earlier than the first edge following release.

Configuration
REQ-034 The macro SCAN_DECODER_ERR_EN SHALL control an additional output err (1 bit).
REQ-035 With SCAN_DECODER_ERR_EN defined, err SHALL become sticky-1 one cycle after sel_valid=1 is seen while in SCAN with en=1.
REQ-036 With SCAN_DECODER_ERR_EN defined, err SHALL be cleared only by reset.
REQ-037 Without SCAN_DECODER_ERR_EN, the err port and its logic SHALL be absent, and sel_valid in SCAN SHALL be silently ignored.

Structure
REQ-038 The shared package scan_dec_pkg SHALL hold the FSM state enum (IDLE/DIRECT/SCAN) and the polarity constants.
REQ-039 The combinational index-to-one-hot logic SHALL be a sub-module dec_onehot (parameters SEL_W and ACT_HIGH) whose output is registered in scan_decoder.

Verification
REQ-040 The bench SHALL check: SEL_W=2, ACT_HIGH=1, direct mode, transfers sel=0,1,2,3 -> dout 0001,0010,0100,1000, each one cycle after its transfer.
REQ-041 The bench SHALL check: ACT_HIGH=0, sel=2 -> dout=1011; en=0 -> dout=1111 next cycle.
REQ-042 The bench SHALL check: SCAN, dwell=2 -> each index is held for 3 cycles, the order is 0,1,2,3,0, and wrap pulses once on the 3->0 transition.
REQ-043 The bench SHALL check: SCAN, dwell=0, en dropped at index 2 for 5 cycles -> dout is inactive, then resumes at index 2 and advances normally.
REQ-044 The bench SHALL check: rst_n asserted mid-scan at index 3 -> dout inactive and cur_idx=0 asynchronously, IDLE after release.
REQ-045 The bench SHALL check, with SCAN_DECODER_ERR_EN defined: sel_valid=1 during SCAN -> err=1 next cycle and it stays 1 through a mode switch until reset.
